// File: rtl/board_clear_sequencer.sv
// board_clear_sequencer
//   Consumes the confirmed erase/restart command levels from the TicTacToe
//   menu logic. Erase writes EMPTY_CODE into every board cell and resets the
//   turn. Restart does the same and also clears both player scores. The
//   board RAM is written one cell per cycle. Player moves are locked out
//   while a sequence runs. A one-cycle done pulse marks the end.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   erase_req        erase command level (rising edge starts an erase)
//   restart_req      restart command level (rising edge starts a restart)
//   cell_we          board RAM write enable
//   cell_addr        board RAM write address (holds when cell_we=0)
//   cell_wdata       board RAM write data, constant EMPTY_CODE
//   score_clr        one-cycle pulse clearing both score counters
//   turn_rst         one-cycle pulse returning the turn to player X
//   game_lock        high while a sequence is in progress
//   done             one-cycle completion pulse
//   last_was_restart mode of the most recently completed sequence
module board_clear_sequencer #(
  parameter int CELLS      = 9,
  parameter int ADDR_W     = 4,
  parameter int CELL_W     = 2,
  parameter int EMPTY_CODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              erase_req,
  input  logic              restart_req,
  output logic              cell_we,
  output logic [ADDR_W-1:0] cell_addr,
  output logic [CELL_W-1:0] cell_wdata,
  output logic              score_clr,
  output logic              turn_rst,
  output logic              game_lock,
  output logic              done,
  output logic              last_was_restart
);

  typedef enum logic [1:0] {IDLE, CLEAR, SCORE, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              mode_q, mode_d;  // 1 = restart, 0 = erase
  logic              erase_prev_q, restart_prev_q;
  logic              rise_e, rise_r;

  logic              cell_we_q;
  logic [ADDR_W-1:0] cell_addr_q;
  logic              score_clr_q, turn_rst_q, game_lock_q, done_q, last_q;

  assign rise_e = erase_req & ~erase_prev_q;
  assign rise_r = restart_req & ~restart_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        // Restart has priority over a simultaneous erase.
        if (rise_r) begin
          state_d = CLEAR;
          cnt_d   = '0;
          mode_d  = 1'b1;
        end else if (rise_e) begin
          state_d = CLEAR;
          cnt_d   = '0;
          mode_d  = 1'b0;
        end
      end
      CLEAR: begin
        // A restart arriving mid-sweep upgrades an erase; the sweep carries
        // on and the score clear is appended. The upgrade also counts on
        // the final write cycle, so the branch below uses mode_d.
        if (rise_r) mode_d = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = mode_d ? SCORE : FINISH;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      SCORE:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so that they line up
  // with the registered state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mode_q         <= 1'b0;
      erase_prev_q   <= 1'b0;
      restart_prev_q <= 1'b0;
      cell_we_q      <= 1'b0;
      cell_addr_q    <= '0;
      score_clr_q    <= 1'b0;
      turn_rst_q     <= 1'b0;
      game_lock_q    <= 1'b0;
      done_q         <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      erase_prev_q   <= erase_req;
      restart_prev_q <= restart_req;
      cell_we_q      <= (state_d == CLEAR);
      if (state_d == CLEAR) cell_addr_q <= cnt_d;
      score_clr_q    <= (state_d == SCORE);
      turn_rst_q     <= (state_d == FINISH);
      done_q         <= (state_d == FINISH);
      game_lock_q    <= (state_d != IDLE);
      // Mode is frozen by the time FINISH is reached; publish it afterwards.
      if (state_q == FINISH) last_q <= mode_q;
    end
  end

  assign cell_we          = cell_we_q;
  assign cell_addr        = cell_addr_q;
  assign cell_wdata       = CELL_W'(EMPTY_CODE);
  assign score_clr        = score_clr_q;
  assign turn_rst         = turn_rst_q;
  assign game_lock        = game_lock_q;
  assign done             = done_q;
  assign last_was_restart = last_q;

endmodule

// File: tb/tb_board_clear_sequencer.sv
module tb_board_clear_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // default instance (CELLS=9)
  logic       erase_req = 1'b0, restart_req = 1'b0;
  logic       cell_we, score_clr, turn_rst, game_lock, done, last_was_restart;
  logic [3:0] cell_addr;
  logic [1:0] cell_wdata;

  // small instance (CELLS=4)
  logic       erase_req4 = 1'b0, restart_req4 = 1'b0;
  logic       cell_we4, score_clr4, turn_rst4, game_lock4, done4, last_was_restart4;
  logic [3:0] cell_addr4;
  logic [1:0] cell_wdata4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  board_clear_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .erase_req(erase_req), .restart_req(restart_req),
    .cell_we(cell_we), .cell_addr(cell_addr), .cell_wdata(cell_wdata),
    .score_clr(score_clr), .turn_rst(turn_rst), .game_lock(game_lock),
    .done(done), .last_was_restart(last_was_restart)
  );

  board_clear_sequencer #(.CELLS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .erase_req(erase_req4), .restart_req(restart_req4),
    .cell_we(cell_we4), .cell_addr(cell_addr4), .cell_wdata(cell_wdata4),
    .score_clr(score_clr4), .turn_rst(turn_rst4), .game_lock(game_lock4),
    .done(done4), .last_was_restart(last_was_restart4)
  );

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs_v, exp_v);
    end
  endtask

  // packed view: {we, addr[3:0], wdata[1:0], score_clr, turn_rst, game_lock, done}
  function automatic logic [10:0] obs(input bit which);
    if (which)
      return {cell_we4, cell_addr4, cell_wdata4, score_clr4, turn_rst4, game_lock4, done4};
    return {cell_we, cell_addr, cell_wdata, score_clr, turn_rst, game_lock, done};
  endfunction

  function automatic logic last_of(input bit which);
    return which ? last_was_restart4 : last_was_restart;
  endfunction

  // Expected outputs in cycle T+k of a sequence over n cells.
  function automatic logic [10:0] exp_vec(input int k, input int n, input bit r);
    int f;
    logic       we, sc, tr, lk, dn;
    logic [3:0] addr;
    f  = n + (r ? 2 : 1);
    we = 1'b0; sc = 1'b0; tr = 1'b0; lk = 1'b0; dn = 1'b0;
    addr = 4'(n - 1);
    if (k >= 1 && k <= n) begin
      we = 1'b1; lk = 1'b1; addr = 4'(k - 1);
    end else if (r && k == n + 1) begin
      sc = 1'b1; lk = 1'b1;
    end else if (k == f) begin
      tr = 1'b1; dn = 1'b1; lk = 1'b1;
    end
    return {we, addr, 2'b00, sc, tr, lk, dn};
  endfunction

  task automatic drive_e(input bit which, input logic v);
    if (which) erase_req4 = v; else erase_req = v;
  endtask

  task automatic drive_r(input bit which, input logic v);
    if (which) restart_req4 = v; else restart_req = v;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Raise the given requests in cycle T, then check cycles T+1..T+f+1.
  // Unless held, requests drop in T+1; k_e/k_r re-raise erase/restart in that cycle.
  task automatic run_seq(input bit which, input int n, input bit e0, input bit r0,
                         input bit hold, input bit exp_r, input int k_e, input int k_r,
                         input string name);
    int f;
    f = n + (exp_r ? 2 : 1);
    drive_e(which, e0);
    drive_r(which, r0);
    for (int k = 1; k <= f + 1; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s k=%0d", name, k), 32'(obs(which)), 32'(exp_vec(k, n, exp_r)));
      if (k == 1 && !hold) begin
        drive_e(which, 1'b0);
        drive_r(which, 1'b0);
      end
      if (k == k_e) drive_e(which, 1'b1);
      if (k == k_r) drive_r(which, 1'b1);
    end
    chk({name, " last_was_restart"}, 32'(last_of(which)), 32'(exp_r));
  endtask

  initial begin
    // reset state
    #2;
    chk("reset outputs", 32'(obs(0)), 32'd0);
    chk("reset last", 32'(last_was_restart), 32'd0);
    chk("reset outputs4", 32'(obs(1)), 32'd0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    chk("idle after reset", 32'(obs(0)), 32'd0);

    // 1: erase pulse
    run_seq(0, 9, 1, 0, 0, 0, 0, 0, "erase");
    tick(2);

    // 2: restart held 50 cycles, exactly one sequence
    run_seq(0, 9, 0, 1, 1, 1, 0, 0, "restart_held");
    for (int i = 0; i < 38; i++) begin
      @(posedge clk); #1;
      chk($sformatf("held idle i=%0d", i), 32'(obs(0)), 32'(exp_vec(100, 9, 1)));
    end
    drive_r(0, 1'b0);
    tick(2);
    run_seq(0, 9, 0, 1, 0, 1, 0, 0, "restart_again");
    tick(2);

    // erase after restart: last_was_restart falls back to 0
    run_seq(0, 9, 1, 0, 0, 0, 0, 0, "erase2");
    tick(2);

    // 4: erase upgraded by restart at addr=4, erase re-pressed at addr=2
    run_seq(0, 9, 1, 0, 0, 1, 3, 5, "upgrade");
    drive_e(0, 1'b0);
    drive_r(0, 1'b0);
    tick(2);

    run_seq(0, 9, 1, 0, 0, 0, 0, 0, "erase3");
    tick(2);

    // 3: simultaneous rise, restart wins
    run_seq(0, 9, 1, 1, 0, 1, 0, 0, "simul");
    tick(2);

    // 5: reset during CLEAR at addr=5, erase held through release
    drive_e(0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("pre_abort k=%0d", k), 32'(obs(0)), 32'(exp_vec(k, 9, 0)));
    end
    rst_n = 1'b0;
    #1;
    chk("abort async outputs", 32'(obs(0)), 32'd0);
    chk("abort last", 32'(last_was_restart), 32'd0);
    @(posedge clk); #1;
    chk("abort held outputs", 32'(obs(0)), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_seq(0, 9, 1, 0, 1, 0, 0, 0, "post_abort");
    drive_e(0, 1'b0);
    tick(2);

    // 6: CELLS=4 instance
    run_seq(1, 4, 1, 0, 0, 0, 0, 0, "c4_erase");
    tick(2);
    run_seq(1, 4, 0, 1, 0, 1, 0, 0, "c4_restart");
    tick(2);
    chk("c4 idle", 32'(obs(1)), 32'(exp_vec(100, 4, 1)));
    chk("dut idle", 32'(obs(0)), 32'(exp_vec(100, 9, 0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/board_clear_sequencer.md
Name: board_clear_sequencer

Overview:
- Consumer of the confirmed erase/restart command pulses from the TicTacToe menu/button logic.
- Erase clears the 9-cell board RAM and resets the turn.
- Restart does the same and also clears both player scores.
- Sequences the RAM writes one cell per cycle, locks out player moves while busy, and signals completion with a one-cycle done pulse.

Parameters:
- CELLS, 9, number of board cells written per clear; legal range 1..16.
- ADDR_W, 4, width of cell_addr; must satisfy 2^ADDR_W >= CELLS.
- CELL_W, 2, width of one cell word.
- EMPTY_CODE, 0, value written to each cell (00 = empty).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- erase_req  in  1  erase command level, synchronous to clk; may stay high many cycles.
- restart_req  in  1  restart command level, synchronous to clk; may stay high many cycles.
- cell_we  out  1  board RAM write enable.
- cell_addr  out  ADDR_W  board RAM write address.
- cell_wdata  out  CELL_W  board RAM write data; always EMPTY_CODE.
- score_clr  out  1  one-cycle pulse that clears both score counters.
- turn_rst  out  1  one-cycle pulse that returns the turn to player X.
- game_lock  out  1  high while busy; the move logic ignores presses while high.
- done  out  1  one-cycle completion pulse.
- last_was_restart  out  1  mode of the most recently completed sequence (1 = restart).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - All outputs 0, cell_addr=0.
  - Edge registers erase_prev and restart_prev are set to 0, so a request already high when reset releases counts as one rising edge.
- Edge detect:
  - rise_e = erase_req & ~erase_prev; rise_r = restart_req & ~restart_prev.
  - The prev registers update every cycle.
  - A held level never retriggers; the request must drop, then rise again.
- States: IDLE, CLEAR, SCORE, FINISH. Outputs are Moore decodes of registered state and counter.
- IDLE:
  - If rise_r: go to CLEAR, mode=restart.
  - Else if rise_e: go to CLEAR, mode=erase.
  - Simultaneous rise_r and rise_e: restart wins.
  - On entry to CLEAR, counter=0.
- CLEAR:
  - cell_we=1, cell_addr=counter, counter increments each cycle.
  - At counter==CELLS-1, go to SCORE if mode=restart, else FINISH.
  - Exactly CELLS writes, addresses 0..CELLS-1 in order, no gaps or repeats.
- SCORE: score_clr=1 for one cycle, then go to FINISH.
- FINISH:
  - turn_rst=1 and done=1 for one cycle.
  - last_was_restart <= mode, registered; visible from the cycle after FINISH.
  - Then go to IDLE.
- game_lock = 1 in CLEAR, SCORE and FINISH.
- Latency, counted from the clk edge that samples the rising request:
  - First write occurs in the next cycle.
  - Erase: busy for CELLS+1 cycles (10 at default).
  - Restart: busy for CELLS+2 cycles (11 at default).
- Requests while busy:
  - rise_e is ignored.
  - rise_r while mode=erase upgrades mode to restart. If in CLEAR, the current sweep continues; SCORE runs afterwards. If in FINISH, the upgrade is ignored.
  - rise_r while mode=restart is ignored.
  - No queuing; a dropped request is not remembered.
- cell_addr holds its last value when cell_we=0. It is don't-care for the RAM, but the bench checks it is stable.
- Reset mid-sequence: abort immediately to the reset values.
  - The partial clear is not resumed; no done pulse.
  - The board is left partially cleared and the controller must re-request.
- Counter wraps only through the reset-to-0 on CLEAR entry; it never counts past CELLS-1.

Test Plan:
1. Erase pulse:
   - Stimulus: erase_req high for 1 cycle at T.
   - Response: cell_we high T+1..T+9 with addr 0..8, wdata=0; score_clr never; turn_rst and done at T+10; game_lock high T+1..T+10; last_was_restart=0 afterwards.
2. Restart held 50 cycles:
   - Response: addr 0..8 at T+1..T+9; score_clr at T+10; done and turn_rst at T+11.
   - Exactly one sequence while held; no second sequence until the level drops and rises again.
3. Simultaneous rise of erase_req and restart_req:
   - Response: restart sequence (score_clr present); last_was_restart=1.
4. Erase started, restart rises during CLEAR (addr=4):
   - Response: writes continue to addr 8; score_clr follows; done at T+11.
   - Erase re-pressed during CLEAR: no effect.
5. rst_n low during CLEAR at addr=5:
   - Response: all outputs 0 asynchronously, no done.
   - After release with erase_req still high: a fresh 10-cycle erase starts at addr 0.
6. CELLS=4 override:
   - Response: erase writes addr 0..3, done at T+5; restart done at T+6.
